// File: rtl/ymat_addr_gen_pkg.sv
// Shared types and sizing helpers for the Y-matrix row-address generator.
// Latency: n/a (types, constants and elaboration-time functions only).
// Backpressure: n/a.
package ymat_addr_gen_pkg;

    localparam int DEF_WORD_W  = 256;
    localparam int DEF_LANE_W  = 16;
    localparam int DEF_FIELD_W = 10;
    localparam int DEF_ADDR_W  = 11;
    localparam int DEF_ROW_W   = 16;
    localparam int DEF_RD_LAT  = 1;
    localparam int DEF_LANES   = DEF_WORD_W / DEF_LANE_W;
    localparam int DEF_LSEL_W  = $clog2(DEF_LANES);
    localparam int DEF_TAG_W   = DEF_ROW_W - DEF_LSEL_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } stateT;

    // Number of row-index bits that select a lane inside one SRAM word.
    function automatic int laneSelW(input int wordW, input int laneW);
        return $clog2(wordW / laneW);
    endfunction

    function automatic bit isPow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/ymat_addr_gen_if.sv
// Request, index-SRAM read and address-pair output bundle of the row-address generator.
// Latency: n/a (wires only).
// Backpressure: req_ready / out_ready handshakes; the SRAM port has no backpressure.
interface ymat_addr_gen_if
    import ymat_addr_gen_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int ROW_W  = DEF_ROW_W,
    parameter int TAG_W  = DEF_TAG_W
);
    logic              req_valid;
    logic              req_ready;
    logic [ROW_W-1:0]  req_row;
    logic              mem_rd_en;
    logic [TAG_W-1:0]  mem_rd_addr;
    logic [WORD_W-1:0] mem_rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr1;
    logic [ADDR_W-1:0] out_addr2;
    logic              out_wrap;
    logic              out_hit;

    // Address generator side.
    modport slave (
        input  req_valid, req_row, mem_rd_data, out_ready,
        output req_ready, mem_rd_en, mem_rd_addr,
               out_valid, out_addr1, out_addr2, out_wrap, out_hit
    );

    // Row sequencer / SRAM / consumer side.
    modport master (
        output req_valid, req_row, mem_rd_data, out_ready,
        input  req_ready, mem_rd_en, mem_rd_addr,
               out_valid, out_addr1, out_addr2, out_wrap, out_hit
    );
endinterface

// File: rtl/ymat_lane_mux.sv
// Selects one packed lane of an index word and zero-extends its low FIELD_W bits.
// Latency: combinational.
// Backpressure: none.
module ymat_lane_mux #(
    parameter int WORD_W  = 256,
    parameter int LANE_W  = 16,
    parameter int FIELD_W = 10,
    parameter int ADDR_W  = 11,
    parameter int LSEL_W  = 4
) (
    input  logic [WORD_W-1:0] word,
    input  logic [LSEL_W-1:0] lane,
    output logic [ADDR_W-1:0] field
);
    localparam int LANES = WORD_W / LANE_W;

    // Lane 0 sits at the MSBs, so lane k is shifted down by (LANES-1-k) lanes.
    always_comb begin
        field = ADDR_W'(FIELD_W'(word >> ((LANES - 1 - int'(lane)) * LANE_W)));
    end
endmodule

// File: rtl/ymat_addr_gen.sv
// Row index -> (addr1, addr1+1) via index-SRAM lookup with a one-word tag cache.
// Latency: 1 cycle on a cache hit, RD_LAT+2 cycles on a miss.
// Backpressure: pair held until out_ready; req_ready only in IDLE or when OUT drains.
module ymat_addr_gen
    import ymat_addr_gen_pkg::*;
#(
    parameter int WORD_W  = DEF_WORD_W,
    parameter int LANE_W  = DEF_LANE_W,
    parameter int FIELD_W = DEF_FIELD_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int ROW_W   = DEF_ROW_W,
    parameter int RD_LAT  = DEF_RD_LAT
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           flush,
    ymat_addr_gen_if.slave bus
);
    localparam int LANES  = WORD_W / LANE_W;
    localparam int LSEL_W = laneSelW(WORD_W, LANE_W);
    localparam int TAG_W  = ROW_W - LSEL_W;
    localparam int CNT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    if ((WORD_W % LANE_W) != 0 || !isPow2(LANES) || RD_LAT < 1 ||
        FIELD_W > LANE_W || FIELD_W > ADDR_W) begin : gBadParams
        $error("ymat_addr_gen: illegal parameter combination");
    end

    stateT              state;
    logic [CNT_W-1:0]   waitCnt;
    logic               cValid;
    logic [TAG_W-1:0]   cTag;
    logic [WORD_W-1:0]  cWord;
    logic               fillOk;
    logic [LSEL_W-1:0]  pendLane;

    logic [LSEL_W-1:0]  reqLane;
    logic [TAG_W-1:0]   reqTag;
    logic               accept;
    logic               isHit;
    logic [WORD_W-1:0]  muxWord;
    logic [LSEL_W-1:0]  muxLane;
    logic [ADDR_W-1:0]  field;

    assign reqLane       = bus.req_row[LSEL_W-1:0];
    assign reqTag        = bus.req_row[ROW_W-1:LSEL_W];
    assign bus.req_ready = (state == IDLE) || ((state == OUT) && bus.out_ready);
    assign accept        = bus.req_valid && bus.req_ready;
    // A flush in the accept cycle must not be served from the word it is invalidating.
    assign isHit         = cValid && (cTag == reqTag) && !flush;

    // One extractor: fresh SRAM data while waiting on a miss, otherwise the cached word.
    always_comb begin
        muxWord = cWord;
        muxLane = reqLane;
        if (state == WAIT) begin
            muxWord = bus.mem_rd_data;
            muxLane = pendLane;
        end
    end

    ymat_lane_mux #(
        .WORD_W (WORD_W),
        .LANE_W (LANE_W),
        .FIELD_W(FIELD_W),
        .ADDR_W (ADDR_W),
        .LSEL_W (LSEL_W)
    ) uLaneMux (
        .word (muxWord),
        .lane (muxLane),
        .field(field)
    );

    // Request FSM, SRAM read sequencing, cache fill and registered output pair.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            waitCnt         <= '0;
            cValid          <= 1'b0;
            cTag            <= '0;
            cWord           <= '0;
            fillOk          <= 1'b0;
            pendLane        <= '0;
            bus.mem_rd_en   <= 1'b0;
            bus.mem_rd_addr <= '0;
            bus.out_valid   <= 1'b0;
            bus.out_addr1   <= '0;
            bus.out_addr2   <= '0;
            bus.out_wrap    <= 1'b0;
            bus.out_hit     <= 1'b0;
        end else begin
            bus.mem_rd_en <= 1'b0;
            if (flush) begin
                cValid <= 1'b0;
            end
            case (state)
                IDLE, OUT: begin
                    if ((state == OUT) && bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                    end
                    if (accept) begin
                        if (isHit) begin
                            bus.out_addr1 <= field;
                            bus.out_addr2 <= field + 1'b1;
                            bus.out_wrap  <= &field;
                            bus.out_hit   <= 1'b1;
                            bus.out_valid <= 1'b1;
                            state         <= OUT;
                        end else begin
                            bus.mem_rd_en   <= 1'b1;
                            bus.mem_rd_addr <= reqTag;
                            pendLane        <= reqLane;
                            fillOk          <= 1'b1;
                            state           <= READ;
                        end
                    end
                end
                READ: begin
                    waitCnt <= CNT_W'(RD_LAT - 1);
                    if (flush) begin
                        fillOk <= 1'b0;
                    end
                    state <= WAIT;
                end
                WAIT: begin
                    if (flush) begin
                        fillOk <= 1'b0;
                    end
                    if (waitCnt == '0) begin
                        // A flush anywhere during the fetch keeps the word out of the cache.
                        if (fillOk && !flush) begin
                            cValid <= 1'b1;
                            cTag   <= bus.mem_rd_addr;
                            cWord  <= bus.mem_rd_data;
                        end
                        bus.out_addr1 <= field;
                        bus.out_addr2 <= field + 1'b1;
                        bus.out_wrap  <= &field;
                        bus.out_hit   <= 1'b0;
                        bus.out_valid <= 1'b1;
                        state         <= OUT;
                    end else begin
                        waitCnt <= waitCnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ymat_addr_gen.sv
// Self-checking bench for ymat_addr_gen: two instances (10-bit and 11-bit fields).
// Latency: n/a.
// Backpressure: consumer stalls driven from the scenarios.
module tb_ymat_addr_gen;
    localparam int WORD_W = 256;
    localparam int LANE_W = 16;
    localparam int ROW_W  = 16;
    localparam int TAG_W  = 12;
    localparam int ADDR_W = 11;
    localparam int FWA    = 10;
    localparam int FWB    = 11;
    localparam int RDA    = 1;
    localparam int RDB    = 3;

    logic clock  = 1'b0;
    logic reset  = 1'b0;
    logic flushA = 1'b0;
    logic flushB = 1'b0;

    always #5 clock = ~clock;

    ymat_addr_gen_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .ROW_W(ROW_W), .TAG_W(TAG_W)) a ();
    ymat_addr_gen_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .ROW_W(ROW_W), .TAG_W(TAG_W)) b ();

    ymat_addr_gen #(.WORD_W(WORD_W), .LANE_W(LANE_W), .FIELD_W(FWA), .ADDR_W(ADDR_W),
                    .ROW_W(ROW_W), .RD_LAT(RDA))
        dutA (.clock(clock), .reset(reset), .flush(flushA), .bus(a.slave));

    ymat_addr_gen #(.WORD_W(WORD_W), .LANE_W(LANE_W), .FIELD_W(FWB), .ADDR_W(ADDR_W),
                    .ROW_W(ROW_W), .RD_LAT(RDB))
        dutB (.clock(clock), .reset(reset), .flush(flushB), .bus(b.slave));

    int nCmp  = 0;
    int nFail = 0;

    // Index SRAM models: data presented exactly RD_LAT cycles after the read strobe, junk otherwise.
    logic [WORD_W-1:0] memA [1 << TAG_W];
    logic [WORD_W-1:0] memB [1 << TAG_W];
    bit                vA [RDA];
    bit                vB [RDB];
    logic [TAG_W-1:0]  pA [RDA];
    logic [TAG_W-1:0]  pB [RDB];
    logic [WORD_W-1:0] junk;
    int                rdCntA = 0;
    int                rdCntB = 0;
    logic [TAG_W-1:0]  lastRdA;

    always @(posedge clock) begin
        for (int i = RDA - 1; i > 0; i--) begin
            vA[i] <= vA[i-1];
            pA[i] <= pA[i-1];
        end
        vA[0] <= a.mem_rd_en;
        pA[0] <= a.mem_rd_addr;
        for (int i = RDB - 1; i > 0; i--) begin
            vB[i] <= vB[i-1];
            pB[i] <= pB[i-1];
        end
        vB[0] <= b.mem_rd_en;
        pB[0] <= b.mem_rd_addr;
        for (int i = 0; i < WORD_W / 32; i++) junk[i*32 +: 32] <= $urandom;
        if (a.mem_rd_en) begin
            rdCntA  <= rdCntA + 1;
            lastRdA <= a.mem_rd_addr;
        end
        if (b.mem_rd_en) rdCntB <= rdCntB + 1;
    end

    assign a.mem_rd_data = vA[RDA-1] ? memA[pA[RDA-1]] : junk;
    assign b.mem_rd_data = vB[RDB-1] ? memB[pB[RDB-1]] : junk;

    // Reference cache state: which word (if any) a request may be served from.
    bit               mValidA = 0;
    bit               mValidB = 0;
    logic [TAG_W-1:0] mTagA   = '0;

    // Field of lane k: lane k is the k-th 16-bit group counted from the MSB end.
    function automatic logic [ADDR_W-1:0] refField(input logic [WORD_W-1:0] w, input int lane,
                                                   input int fw);
        logic [WORD_W-1:0] s;
        int                lv;
        s  = w >> (WORD_W - (lane + 1) * LANE_W);
        lv = int'(s[LANE_W-1:0]);
        return ADDR_W'(lv % (1 << fw));
    endfunction

    function automatic logic [ADDR_W-1:0] refNext(input logic [ADDR_W-1:0] v);
        return ADDR_W'((int'(v) + 1) % (1 << ADDR_W));
    endfunction

    // Present a request, wait for acceptance, then wait for the pair; ends on a negedge.
    task automatic reqA(input logic [ROW_W-1:0] row, input logic fl, output int lat, output bit to);
        int n;
        to = 0;
        a.req_row = row; a.req_valid = 1'b1; flushA = fl;
        n = 0;
        @(negedge clock);
        while (!a.req_ready && n < 50) begin @(negedge clock); n++; end
        if (!a.req_ready) to = 1;
        @(posedge clock); #1;
        a.req_valid = 1'b0; flushA = 1'b0; a.req_row = ROW_W'($urandom);
        @(negedge clock); lat = 1;
        while (!a.out_valid && lat < 50) begin @(negedge clock); lat++; end
        if (!a.out_valid) to = 1;
    endtask

    task automatic reqB(input logic [ROW_W-1:0] row, output int lat, output bit to);
        int n;
        to = 0;
        b.req_row = row; b.req_valid = 1'b1;
        n = 0;
        @(negedge clock);
        while (!b.req_ready && n < 50) begin @(negedge clock); n++; end
        if (!b.req_ready) to = 1;
        @(posedge clock); #1;
        b.req_valid = 1'b0; b.req_row = ROW_W'($urandom);
        @(negedge clock); lat = 1;
        while (!b.out_valid && lat < 50) begin @(negedge clock); lat++; end
        if (!b.out_valid) to = 1;
    endtask

    task automatic popA;
        a.out_ready = 1'b1;
        @(posedge clock); #1;
        a.out_ready = 1'b0;
    endtask

    task automatic popB;
        b.out_ready = 1'b1;
        @(posedge clock); #1;
        b.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        nCmp++; if (a.out_valid !== 1'b0) begin nFail++; $display("FAIL reset_valid: got %b want 0", a.out_valid); end
        nCmp++; if (a.out_addr1 !== 11'h0) begin nFail++; $display("FAIL reset_addr1: got %h want 000", a.out_addr1); end
        nCmp++; if (a.out_addr2 !== 11'h0) begin nFail++; $display("FAIL reset_addr2: got %h want 000", a.out_addr2); end
        nCmp++; if (a.mem_rd_en !== 1'b0) begin nFail++; $display("FAIL reset_rd_en: got %b want 0", a.mem_rd_en); end
        nCmp++; if (b.out_valid !== 1'b0) begin nFail++; $display("FAIL reset_valid_b: got %b want 0", b.out_valid); end
        reset = 1'b1;
        @(negedge clock);
        nCmp++; if (a.req_ready !== 1'b1) begin nFail++; $display("FAIL reset_req_ready: got %b want 1", a.req_ready); end
        @(posedge clock); #1;
        mValidA = 0; mValidB = 0;
    endtask

    task automatic test_miss;
        int lat; bit to; int r0;
        r0 = rdCntA;
        reqA(16'h0013, 1'b0, lat, to);
        nCmp++; if (to !== 1'b0) begin nFail++; $display("FAIL miss_timeout: handshake did not complete"); end
        nCmp++; if (lat !== RDA + 2) begin nFail++; $display("FAIL miss_latency: got %0d want %0d", lat, RDA + 2); end
        nCmp++; if (rdCntA - r0 !== 1) begin nFail++; $display("FAIL miss_rd_count: got %0d want 1", rdCntA - r0); end
        nCmp++; if (lastRdA !== 12'h001) begin nFail++; $display("FAIL miss_rd_addr: got %h want 001", lastRdA); end
        nCmp++; if (a.out_addr1 !== 11'h155) begin nFail++; $display("FAIL miss_addr1: got %h want 155", a.out_addr1); end
        nCmp++; if (a.out_addr2 !== 11'h156) begin nFail++; $display("FAIL miss_addr2: got %h want 156", a.out_addr2); end
        nCmp++; if (a.out_hit !== 1'b0) begin nFail++; $display("FAIL miss_hit: got %b want 0", a.out_hit); end
        popA;
        mValidA = 1; mTagA = 12'h001;
    endtask

    task automatic test_hit;
        int lat; bit to; int r0;
        r0 = rdCntA;
        reqA(16'h001F, 1'b0, lat, to);
        nCmp++; if (to !== 1'b0) begin nFail++; $display("FAIL hit_timeout: handshake did not complete"); end
        nCmp++; if (lat !== 1) begin nFail++; $display("FAIL hit_latency: got %0d want 1", lat); end
        nCmp++; if (rdCntA - r0 !== 0) begin nFail++; $display("FAIL hit_rd_count: got %0d want 0", rdCntA - r0); end
        nCmp++; if (a.out_addr1 !== 11'h3FF) begin nFail++; $display("FAIL hit_addr1: got %h want 3ff", a.out_addr1); end
        nCmp++; if (a.out_addr2 !== 11'h400) begin nFail++; $display("FAIL hit_addr2: got %h want 400", a.out_addr2); end
        nCmp++; if (a.out_hit !== 1'b1) begin nFail++; $display("FAIL hit_flag: got %b want 1", a.out_hit); end
        popA;
    endtask

    task automatic test_back_to_back;
        int lat; bit to;
        logic [ADDR_W-1:0] e1, e2;
        e1 = refField(memA[2], 0, FWA);
        reqA(16'h0020, 1'b0, lat, to);
        nCmp++; if (to !== 1'b0 || a.out_addr1 !== e1) begin nFail++; $display("FAIL b2b_first: got %h want %h", a.out_addr1, e1); end
        mValidA = 1; mTagA = 12'h002;
        a.req_row = 16'h0025; a.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            nCmp++;
            if (a.out_valid !== 1'b1 || a.out_addr1 !== e1 || a.out_addr2 !== refNext(e1) || a.req_ready !== 1'b0) begin
                nFail++; $display("FAIL b2b_stall%0d: valid %b addr1 %h rdy %b want 1 %h 0", i, a.out_valid, a.out_addr1, a.req_ready, e1);
            end
        end
        a.out_ready = 1'b1; #1;
        nCmp++; if (a.req_ready !== 1'b1) begin nFail++; $display("FAIL b2b_ready: got %b want 1", a.req_ready); end
        @(posedge clock); #1;
        a.out_ready = 1'b0; a.req_valid = 1'b0;
        @(negedge clock);
        e2 = refField(memA[2], 5, FWA);
        nCmp++; if (a.out_valid !== 1'b1 || a.out_addr1 !== e2 || a.out_hit !== 1'b1) begin
            nFail++; $display("FAIL b2b_second: valid %b addr1 %h hit %b want 1 %h 1", a.out_valid, a.out_addr1, a.out_hit, e2);
        end
        popA;
    endtask

    task automatic test_flush_wait;
        int lat; bit to; int n; int r0;
        logic [ADDR_W-1:0] e1;
        e1 = refField(memA[3], 7, FWA);
        a.req_row = 16'h0037; a.req_valid = 1'b1;
        @(negedge clock);
        @(posedge clock); #1;            // accepted: READ follows
        a.req_valid = 1'b0;
        @(posedge clock); #1;            // first WAIT cycle
        flushA = 1'b1;
        @(posedge clock); #1;
        flushA = 1'b0;
        n = 0;
        @(negedge clock);
        while (!a.out_valid && n < 20) begin @(negedge clock); n++; end
        nCmp++; if (a.out_valid !== 1'b1 || a.out_addr1 !== e1 || a.out_hit !== 1'b0) begin
            nFail++; $display("FAIL flush_wait_pair: valid %b addr1 %h hit %b want 1 %h 0", a.out_valid, a.out_addr1, a.out_hit, e1);
        end
        popA;
        mValidA = 0;
        r0 = rdCntA;
        reqA(16'h0038, 1'b0, lat, to);
        nCmp++; if (to !== 1'b0 || a.out_hit !== 1'b0 || rdCntA - r0 !== 1) begin
            nFail++; $display("FAIL flush_wait_refetch: hit %b reads %0d want 0 1", a.out_hit, rdCntA - r0);
        end
        nCmp++; if (a.out_addr1 !== refField(memA[3], 8, FWA)) begin nFail++; $display("FAIL flush_wait_addr: got %h", a.out_addr1); end
        popA;
        mValidA = 1; mTagA = 12'h003;
        r0 = rdCntA;
        reqA(16'h0039, 1'b1, lat, to);
        nCmp++; if (to !== 1'b0 || a.out_hit !== 1'b0 || rdCntA - r0 !== 1) begin
            nFail++; $display("FAIL flush_accept_miss: hit %b reads %0d want 0 1", a.out_hit, rdCntA - r0);
        end
        popA;
        flushA = 1'b1;
        @(posedge clock); #1;
        flushA = 1'b0;
        mValidA = 0;
    endtask

    task automatic test_wrap;
        int lat; bit to;
        reqB(16'h0052, lat, to);
        nCmp++; if (to !== 1'b0 || lat !== RDB + 2) begin nFail++; $display("FAIL wrap_latency: got %0d want %0d", lat, RDB + 2); end
        nCmp++; if (b.out_addr1 !== 11'h7FF) begin nFail++; $display("FAIL wrap_addr1: got %h want 7ff", b.out_addr1); end
        nCmp++; if (b.out_addr2 !== 11'h000) begin nFail++; $display("FAIL wrap_addr2: got %h want 000", b.out_addr2); end
        nCmp++; if (b.out_wrap !== 1'b1) begin nFail++; $display("FAIL wrap_flag: got %b want 1", b.out_wrap); end
        popB;
        mValidB = 1;
        reqB(16'h0057, lat, to);
        nCmp++; if (to !== 1'b0 || lat !== 1 || b.out_hit !== 1'b1) begin nFail++; $display("FAIL wrap_hit: lat %0d hit %b want 1 1", lat, b.out_hit); end
        nCmp++; if (b.out_addr1 !== 11'h123 || b.out_addr2 !== 11'h124 || b.out_wrap !== 1'b0) begin
            nFail++; $display("FAIL nowrap_pair: got %h %h %b want 123 124 0", b.out_addr1, b.out_addr2, b.out_wrap);
        end
        popB;
    endtask

    task automatic test_reset_mid_wait;
        int lat; bit to; int r0; bit seen;
        b.req_row = 16'h0061; b.req_valid = 1'b1;
        @(negedge clock);
        @(posedge clock); #1;            // accepted: READ follows
        b.req_valid = 1'b0;
        @(posedge clock); #1;            // first WAIT cycle; fetched word still in flight
        reset = 1'b0;
        @(negedge clock);
        nCmp++; if (b.out_valid !== 1'b0 || b.out_addr1 !== 11'h0 || b.out_addr2 !== 11'h0 || b.out_hit !== 1'b0) begin
            nFail++; $display("FAIL rst_wait_outputs: valid %b addr1 %h addr2 %h want 0 0 0", b.out_valid, b.out_addr1, b.out_addr2);
        end
        nCmp++; if (b.mem_rd_en !== 1'b0) begin nFail++; $display("FAIL rst_wait_rd_en: got %b want 0", b.mem_rd_en); end
        reset = 1'b1;
        mValidA = 0; mValidB = 0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (b.out_valid !== 1'b0) seen = 1;
        end
        nCmp++; if (seen !== 1'b0) begin nFail++; $display("FAIL rst_wait_late_data: out_valid rose after reset"); end
        @(posedge clock); #1;
        r0 = rdCntB;
        reqB(16'h0052, lat, to);
        nCmp++; if (to !== 1'b0 || b.out_hit !== 1'b0 || rdCntB - r0 !== 1 || b.out_addr1 !== 11'h7FF) begin
            nFail++; $display("FAIL rst_wait_cache: hit %b reads %0d addr1 %h want 0 1 7ff", b.out_hit, rdCntB - r0, b.out_addr1);
        end
        popB;
    endtask

    task automatic test_random;
        int lat; bit to; int r0; bit expHit;
        logic [ROW_W-1:0] row;
        logic [TAG_W-1:0] tag;
        int lane;
        logic [ADDR_W-1:0] e1;
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 5) == 0) row = ROW_W'($urandom);
            else row = ROW_W'(($urandom_range(4, 7) << 4) | $urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) begin
                flushA = 1'b1;
                @(posedge clock); #1;
                flushA = 1'b0;
                mValidA = 0;
            end
            tag    = row[ROW_W-1:4];
            lane   = int'(row[3:0]);
            expHit = mValidA && (mTagA == tag);
            e1     = refField(memA[tag], lane, FWA);
            r0     = rdCntA;
            reqA(row, 1'b0, lat, to);
            nCmp++; if (to !== 1'b0) begin nFail++; $display("FAIL rnd%0d_timeout: row %h", t, row); end
            nCmp++; if (lat !== (expHit ? 1 : RDA + 2)) begin nFail++; $display("FAIL rnd%0d_latency: got %0d want %0d", t, lat, expHit ? 1 : RDA + 2); end
            nCmp++; if (rdCntA - r0 !== (expHit ? 0 : 1)) begin nFail++; $display("FAIL rnd%0d_reads: got %0d want %0d", t, rdCntA - r0, expHit ? 0 : 1); end
            nCmp++; if (a.out_hit !== expHit) begin nFail++; $display("FAIL rnd%0d_hit: got %b want %b", t, a.out_hit, expHit); end
            nCmp++; if (a.out_addr1 !== e1 || a.out_addr2 !== refNext(e1)) begin
                nFail++; $display("FAIL rnd%0d_pair: got %h %h want %h %h", t, a.out_addr1, a.out_addr2, e1, refNext(e1));
            end
            nCmp++; if (a.out_wrap !== (e1 == 11'h7FF)) begin nFail++; $display("FAIL rnd%0d_wrap: got %b", t, a.out_wrap); end
            if (!expHit) begin mValidA = 1; mTagA = tag; end
            repeat ($urandom_range(0, 3)) @(negedge clock);
            popA;
        end
    endtask

    initial begin
        logic [WORD_W-1:0] w;
        a.req_valid = 1'b0; a.req_row = '0; a.out_ready = 1'b0;
        b.req_valid = 1'b0; b.req_row = '0; b.out_ready = 1'b0;
        for (int i = 0; i < (1 << TAG_W); i++) begin
            for (int j = 0; j < WORD_W / 32; j++) w[j*32 +: 32] = $urandom;
            memA[i] = w;
            for (int j = 0; j < WORD_W / 32; j++) w[j*32 +: 32] = $urandom;
            memB[i] = w;
        end
        memA[1][WORD_W-1-3*LANE_W -: LANE_W] = 16'hFD55;   // lane 3: field 155
        memA[1][LANE_W-1:0]                  = 16'h57FF;   // lane 15: field 3ff
        memB[5][WORD_W-1-2*LANE_W -: LANE_W] = 16'hAFFF;   // lane 2: 11-bit field 7ff
        memB[5][WORD_W-1-7*LANE_W -: LANE_W] = 16'h5123;   // lane 7: 11-bit field 123
        test_reset;
        test_miss;
        test_hit;
        test_back_to_back;
        test_flush_wait;
        test_wrap;
        test_reset_mid_wait;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not reach its summary in time");
        $fatal(1, "watchdog expired");
    end
endmodule
